alu_share_arbiter: RTL

- Shares one 4-op ALU (AND / OR / SUB / ADD) between two requesters, so only one process ever drives the ALU result register.
- Round-robin arbitration with valid/ready request and response handshakes; one operation in flight at a time.
- Sits between two independent command sources and the shared arithmetic resource.

---
 rtl/alu_arb_pkg.sv | 15 +
 rtl/alu_core.sv | 29 ++
 rtl/alu_share_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared opcode constants and FSM state type for alu_share_arbiter
package alu_arb_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational 4-op ALU (AND/OR/SUB/ADD), W-bit operands, W+1-bit result
// Ports:
//   code   in  2    opcode (see alu_arb_pkg)
//   a, b   in  W    operands
//   result out W+1  AND/OR zero-extended; ADD {carry,sum}; SUB a-b mod 2^(W+1)
module alu_core
  import alu_arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [1:0]   code,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   result
);

  always_comb begin
    result = '0;
    case (code)
      OP_AND:  result = {1'b0, a & b};
      OP_OR:   result = {1'b0, a | b};
      // Extending both operands by one bit leaves bit W set on borrow.
      OP_SUB:  result = {1'b0, a} - {1'b0, b};
      OP_ADD:  result = {1'b0, a} + {1'b0, b};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter sharing one ALU between two valid/ready requesters
// Optional feature macro: ALU_ARB_STATS_EN (grant counters + stats_clr)
// Ports:
//   clk, rst                     clock (rising edge), asynchronous active-high reset
//   reqN_valid/ready             command handshake for requester N (ready combinational, IDLE only)
//   reqN_code, reqN_a, reqN_b    opcode and W-bit operands
//   rspN_valid/ready             response handshake for requester N
//   rsp_result                   shared W+1-bit result, meaningful while a rspN_valid is high
//   busy                         high whenever the FSM is not IDLE
//   gnt0_count, gnt1_count       (ALU_ARB_STATS_EN) saturating 16-bit accept counters
//   stats_clr                    (ALU_ARB_STATS_EN) synchronous counter clear
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int W       = 4,
  parameter bit RR_INIT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_code,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_code,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
`ifdef ALU_ARB_STATS_EN
  input  logic         stats_clr,
  output logic [15:0]  gnt0_count,
  output logic [15:0]  gnt1_count,
`endif
  output logic [W:0]   rsp_result,
  output logic         busy
);

  state_t       state, state_next;
  logic         last_grant;
  logic         grant;
  logic         sel;
  logic         accept;
  logic         done;
  logic [1:0]   code_q;
  logic [W-1:0] a_q, b_q;
  logic [W:0]   alu_out;

  // On a tie the requester that was not served last wins; otherwise the
  // lone valid requester is picked. sel is only meaningful with a valid.
  always_comb begin
    if (req0_valid && req1_valid) sel = ~last_grant;
    else                          sel = req1_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    accept     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = req0_valid & ~sel;
        req1_ready = req1_valid & sel;
        accept     = (req0_valid & ~sel) | (req1_valid & sel);
        if (accept) state_next = EXEC;
      end
      EXEC: state_next = RESP;
      RESP: begin
        rsp0_valid = ~grant;
        rsp1_valid = grant;
        // Only the granted requester's rsp_ready can retire the response.
        done = grant ? rsp1_ready : rsp0_ready;
        if (done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      grant      <= 1'b0;
      last_grant <= RR_INIT;
      rsp_result <= '0;
    end else begin
      if (accept) begin
        code_q <= sel ? req1_code : req0_code;
        a_q    <= sel ? req1_a    : req0_a;
        b_q    <= sel ? req1_b    : req0_b;
        grant  <= sel;
      end
      if (state == EXEC) rsp_result <= alu_out;
      if (done)          last_grant <= grant;
    end
  end

  alu_core #(.W(W)) u_alu_core (
    .code   (code_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_out)
  );

`ifdef ALU_ARB_STATS_EN
  // stats_clr has priority over an accept in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt0_count <= '0;
      gnt1_count <= '0;
    end else if (stats_clr) begin
      gnt0_count <= '0;
      gnt1_count <= '0;
    end else begin
      if (accept && !sel && gnt0_count != 16'hFFFF) gnt0_count <= gnt0_count + 16'd1;
      if (accept &&  sel && gnt1_count != 16'hFFFF) gnt1_count <= gnt1_count + 16'd1;
    end
  end
`endif

endmodule
